// File: rtl/disk_pkg.sv
// Shared definitions for the disk image path: geometry, address width
// and the image receiver state encoding.
package disk_pkg;

    localparam int TRACKS      = 35;
    localparam int TRACK_BYTES = 6656;
    localparam int IMAGE_BYTES = TRACKS * TRACK_BYTES;
    localparam int ADDR_W      = 18;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_WAIT_STOP,
        ST_DONE
    } rx_state_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer for an asynchronous strobe followed by a
// registered single-cycle rising-edge pulse.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            last_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

endmodule

// File: rtl/disk_image_receiver.sv
// Receives a strobed floppy image byte stream and writes it linearly
// into track RAM, tracking track number and transfer status.
module disk_image_receiver #(
    parameter int TRACKS      = disk_pkg::TRACKS,
    parameter int TRACK_BYTES = disk_pkg::TRACK_BYTES,
    parameter int SYNC_STAGES = disk_pkg::SYNC_STAGES,
    parameter int ADDR_W      = disk_pkg::ADDR_W
) (
    input  logic              CLK_14M,
    input  logic              RESET_N,
    input  logic              image_clk,
    input  logic              image_start,
    input  logic [7:0]        image_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic [5:0]        track_num,
    output logic              busy,
    output logic              done
);

    import disk_pkg::*;

    localparam int BW = (TRACK_BYTES > 1) ? $clog2(TRACK_BYTES) : 1;

    rx_state_t state_q, state_d;
    logic          rise;
    logic          start_ev;
    logic          data_ev;
    logic          last_byte;
    logic          wr_d;
    logic [BW-1:0] byte_cnt;

    sync_rise_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (CLK_14M),
        .rst_n   (RESET_N),
        .async_in(image_clk),
        .rise    (rise)
    );

    // Pins are already stable by the time the synchronized edge appears.
    assign start_ev  = rise & image_start;
    assign data_ev   = rise & ~image_start;
    assign last_byte = (track_num == 6'(TRACKS - 1)) &&
                       (byte_cnt == BW'(TRACK_BYTES - 1));

    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = 1'b0;
        if (start_ev) begin
            state_d = ST_RECEIVE;
        end else if (data_ev) begin
            unique case (state_q)
                ST_RECEIVE: begin
                    wr_d = 1'b1;
                    if (last_byte) begin
                        state_d = ST_WAIT_STOP;
                    end
                end
                ST_WAIT_STOP: state_d = ST_DONE;
                ST_IDLE:      state_d = ST_IDLE;
                ST_DONE:      state_d = ST_DONE;
            endcase
        end
    end

    // Counters advance on the edge that closes the write cycle.
    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_data  <= 8'd0;
            track_num <= 6'd0;
            byte_cnt  <= '0;
        end else begin
            ram_we <= wr_d;
            if (wr_d) begin
                ram_data <= image_data;
            end
            if (start_ev) begin
                ram_addr  <= '0;
                track_num <= 6'd0;
                byte_cnt  <= '0;
            end else if (ram_we) begin
                ram_addr <= ram_addr + ADDR_W'(1);
                if (byte_cnt == BW'(TRACK_BYTES - 1)) begin
                    byte_cnt  <= '0;
                    track_num <= track_num + 6'd1;
                end else begin
                    byte_cnt <= byte_cnt + BW'(1);
                end
            end
        end
    end

    assign busy = (state_q == ST_RECEIVE) || (state_q == ST_WAIT_STOP);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_disk_image_receiver.sv
// Directed-sequence bench with randomized bytes and strobe timing,
// checked against a linear-count reference model of the receiver.
module tb_disk_image_receiver;

    localparam int TR  = 5;
    localparam int TB  = 12;
    localparam int SS  = 2;
    localparam int AW  = 18;
    localparam int IMG = TR * TB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          image_clk = 1'b0;
    logic          image_start = 1'b0;
    logic [7:0]    image_data = 8'd0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data;
    logic [5:0]    track_num;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    disk_image_receiver #(
        .TRACKS     (TR),
        .TRACK_BYTES(TB),
        .SYNC_STAGES(SS),
        .ADDR_W     (AW)
    ) dut (
        .CLK_14M    (clk),
        .RESET_N    (rst_n),
        .image_clk  (image_clk),
        .image_start(image_start),
        .image_data (image_data),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .track_num  (track_num),
        .busy       (busy),
        .done       (done)
    );

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wq_addr[$];
    logic [7:0]    wq_data[$];
    logic          prev_we = 1'b0;
    int            we_double = 0;

    always @(negedge clk) begin
        if (ram_we) begin
            wq_addr.push_back(ram_addr);
            wq_data.push_back(ram_data);
        end
        if (ram_we && prev_we) we_double++;
        prev_we = ram_we;
    end

    typedef enum {M_IDLE, M_RX, M_WAIT, M_DONE} mode_t;
    mode_t mode = M_IDLE;
    int    m_count = 0;
    int    we_lat;
    int    busy_lat;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic st, input logic [7:0] d);
        int   h;
        int   l;
        logic b0;
        h = $urandom_range(SS + 3, SS + 5);
        l = $urandom_range(SS + 2, SS + 5);
        @(negedge clk);
        image_start = st;
        image_data  = d;
        image_clk   = 1'b1;
        b0       = busy;
        we_lat   = -1;
        busy_lat = -1;
        for (int k = 1; k <= h; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ram_we && we_lat < 0) we_lat = k;
            if (busy !== b0 && busy_lat < 0) busy_lat = k;
        end
        image_clk = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic send(input logic st, input logic [7:0] d);
        strobe(st, d);
        if (st) begin
            mode    = M_RX;
            m_count = 0;
            chk("start_nowr", wq_addr.size(), 0);
            chk("start_addr", ram_addr, 0);
            chk("start_track", track_num, 0);
            chk("start_busy", busy, 1);
            chk("start_done", done, 0);
        end else begin
            case (mode)
                M_RX: begin
                    chk("wr_count", wq_addr.size(), 1);
                    if (wq_addr.size() > 0) begin
                        chk("wr_addr", wq_addr[0], m_count);
                        chk("wr_data", wq_data[0], d);
                    end
                    chk("we_lat", we_lat, SS + 2);
                    m_count++;
                    chk("addr_after", ram_addr, m_count);
                    chk("track_after", track_num, m_count / TB);
                    if (m_count == IMG) mode = M_WAIT;
                    chk("rx_busy", busy, 1);
                    chk("rx_done", done, 0);
                end
                M_WAIT: begin
                    mode = M_DONE;
                    chk("stop_nowr", wq_addr.size(), 0);
                    chk("stop_busy", busy, 0);
                    chk("stop_done", done, 1);
                end
                default: begin
                    chk("ign_nowr", wq_addr.size(), 0);
                    chk("ign_busy", busy, 0);
                    chk("ign_done", done, (mode == M_DONE) ? 1 : 0);
                end
            endcase
        end
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, ram_we, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_data"}, ram_data, 0);
        chk({tag, "_track"}, track_num, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk_zero("rst_low");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk_zero("idle");

        for (int i = 0; i < 3; i++) send(1'b0, 8'($urandom));

        send(1'b1, 8'd0);
        chk("busy_lat", busy_lat, SS + 2);
        for (int n = 0; n < IMG; n++) send(1'b0, 8'((n / TB + n % TB) % 256));
        chk("final_addr", ram_addr, IMG);
        chk("final_track", track_num, TR);
        send(1'b0, 8'($urandom));
        for (int i = 0; i < 2; i++) send(1'b0, 8'($urandom));

        send(1'b1, 8'd0);
        for (int i = 0; i < 30; i++) send(1'b0, 8'($urandom));
        send(1'b1, 8'd0);
        send(1'b0, 8'($urandom));

        send(1'b1, 8'd0);
        while (m_count < 3 * TB + 2) send(1'b0, 8'($urandom));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        mode = M_IDLE;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) send(1'b0, 8'($urandom));
        send(1'b1, 8'd0);
        send(1'b0, 8'($urandom));

        chk("we_width", we_double, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
